// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with a valid/ready handshake and a one-entry skid buffer.
// IN_READY and OUT_VALID are decoded from the registered state only. This means
// neither ready nor valid has a combinational path through the block.
module ex_mem_skid_reg #(
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             IN_FLUSH,
  input  logic [RD_W-1:0]  IN_INSTRUCTION,
  input  logic [XLEN-1:0]  IN_PC,
  input  logic [XLEN-1:0]  IN_ALU_RESULT,
  input  logic [XLEN-1:0]  IN_DATA2,
  input  logic [XLEN-1:0]  IN_IMMEDIATE,
  input  logic             IN_DATAMEMSEL,
  input  logic [3:0]       IN_READ_WRITE,
  input  logic [1:0]       IN_WB_SEL,
  input  logic             IN_REG_WRITE_EN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [RD_W-1:0]  OUT_INSTRUCTION,
  output logic [XLEN-1:0]  OUT_PC,
  output logic [XLEN-1:0]  OUT_ALU_RESULT,
  output logic [XLEN-1:0]  OUT_DATA2,
  output logic [XLEN-1:0]  OUT_IMMEDIATE,
  output logic             OUT_DATAMEMSEL,
  output logic [3:0]       OUT_READ_WRITE,
  output logic [1:0]       OUT_WB_SEL,
  output logic             OUT_REG_WRITE_EN,
  output logic [CNT_W-1:0] OUT_STALL_CNT
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] data2;
    logic [XLEN-1:0] imm;
    logic            dms;
    logic [3:0]      rw;
    logic [1:0]      wb;
    logic            rwe;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic [CNT_W-1:0] stall_q;
  logic out_valid;
  logic in_ready;
  logic accept;
  logic drain;

  assign in_entry = '{rd: IN_INSTRUCTION, pc: IN_PC, alu: IN_ALU_RESULT, data2: IN_DATA2,
                      imm: IN_IMMEDIATE, dms: IN_DATAMEMSEL, rw: IN_READ_WRITE,
                      wb: IN_WB_SEL, rwe: IN_REG_WRITE_EN};

  // The skid holds an entry only in FULL. Ready is simply "the skid is free".
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign accept    = IN_VALID & in_ready;
  assign drain     = out_valid & OUT_READY;

  // Next-state logic. A flush overrides every other event and loads nothing.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (IN_FLUSH) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          case ({accept, drain})
            2'b11: main_d = in_entry;
            2'b10: begin
              skid_d  = in_entry;
              state_d = FULL;
            end
            2'b01: state_d = EMPTY;
            default: state_d = ONE;
          endcase
        end
        FULL: begin
          if (drain) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and entry storage. Reset drops both entries and zeroes every field.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Count cycles where the memory stage back-pressures a valid entry.
  // The count saturates and only reset clears it, so flushes do not hide stalls.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_q <= '0;
    end else if (out_valid && !OUT_READY && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign IN_READY         = in_ready;
  assign OUT_VALID        = out_valid;
  assign OUT_INSTRUCTION  = main_q.rd;
  assign OUT_PC           = main_q.pc;
  assign OUT_ALU_RESULT   = main_q.alu;
  assign OUT_DATA2        = main_q.data2;
  assign OUT_IMMEDIATE    = main_q.imm;
  assign OUT_DATAMEMSEL   = main_q.dms;
  assign OUT_WB_SEL       = main_q.wb;
  // Gate the side effects so a stale main entry can never write memory or the register file.
  assign OUT_READ_WRITE   = out_valid ? main_q.rw : 4'b0000;
  assign OUT_REG_WRITE_EN = out_valid & main_q.rwe;
  assign OUT_STALL_CNT    = stall_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Testbench for ex_mem_skid_reg. A default-width instance is checked against a queue model.
// A 64-bit instance with CNT_W=4 covers the wide fields and stall-counter saturation.
module tb_ex_mem_skid_reg;

  logic clk;
  logic reset;

  logic        in_valid, in_ready, in_flush, out_valid, out_ready;
  logic [4:0]  in_instr, out_instr;
  logic [31:0] in_pc, in_alu, in_data2, in_imm;
  logic [31:0] out_pc, out_alu, out_data2, out_imm;
  logic        in_dms, out_dms, in_rwe, out_rwe;
  logic [3:0]  in_rw, out_rw;
  logic [1:0]  in_wb, out_wb;
  logic [15:0] out_stall;

  logic        w_in_valid, w_in_ready, w_in_flush, w_out_valid, w_out_ready;
  logic [5:0]  w_in_instr, w_out_instr;
  logic [63:0] w_in_pc, w_in_alu, w_in_data2, w_in_imm;
  logic [63:0] w_out_pc, w_out_alu, w_out_data2, w_out_imm;
  logic        w_out_dms, w_out_rwe;
  logic [3:0]  w_out_rw;
  logic [1:0]  w_out_wb;
  logic [3:0]  w_out_stall;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] data2;
    logic [4:0]  rd;
    logic [3:0]  rw;
    logic        rwe;
  } exp_t;

  exp_t q[$];
  logic [15:0] stall_m;
  int checks;
  int failures;

  ex_mem_skid_reg dut (
    .CLK(clk), .RESET(reset),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_FLUSH(in_flush),
    .IN_INSTRUCTION(in_instr), .IN_PC(in_pc), .IN_ALU_RESULT(in_alu),
    .IN_DATA2(in_data2), .IN_IMMEDIATE(in_imm), .IN_DATAMEMSEL(in_dms),
    .IN_READ_WRITE(in_rw), .IN_WB_SEL(in_wb), .IN_REG_WRITE_EN(in_rwe),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT_INSTRUCTION(out_instr), .OUT_PC(out_pc), .OUT_ALU_RESULT(out_alu),
    .OUT_DATA2(out_data2), .OUT_IMMEDIATE(out_imm), .OUT_DATAMEMSEL(out_dms),
    .OUT_READ_WRITE(out_rw), .OUT_WB_SEL(out_wb), .OUT_REG_WRITE_EN(out_rwe),
    .OUT_STALL_CNT(out_stall)
  );

  ex_mem_skid_reg #(.XLEN(64), .RD_W(6), .CNT_W(4)) dut_wide (
    .CLK(clk), .RESET(reset),
    .IN_VALID(w_in_valid), .IN_READY(w_in_ready), .IN_FLUSH(w_in_flush),
    .IN_INSTRUCTION(w_in_instr), .IN_PC(w_in_pc), .IN_ALU_RESULT(w_in_alu),
    .IN_DATA2(w_in_data2), .IN_IMMEDIATE(w_in_imm), .IN_DATAMEMSEL(1'b0),
    .IN_READ_WRITE(4'h0), .IN_WB_SEL(2'b00), .IN_REG_WRITE_EN(1'b0),
    .OUT_VALID(w_out_valid), .OUT_READY(w_out_ready),
    .OUT_INSTRUCTION(w_out_instr), .OUT_PC(w_out_pc), .OUT_ALU_RESULT(w_out_alu),
    .OUT_DATA2(w_out_data2), .OUT_IMMEDIATE(w_out_imm), .OUT_DATAMEMSEL(w_out_dms),
    .OUT_READ_WRITE(w_out_rw), .OUT_WB_SEL(w_out_wb), .OUT_REG_WRITE_EN(w_out_rwe),
    .OUT_STALL_CNT(w_out_stall)
  );

  // Free-running clock. Rising edges fall at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the narrow instance against the model. The model's occupancy drives every expectation.
  task automatic check_output();
    check("out_valid", out_valid, q.size() > 0);
    check("in_ready", in_ready, q.size() < 2);
    check("stall_cnt", out_stall, stall_m);
    if (q.size() > 0) begin
      check("out_alu", out_alu, q[0].alu);
      check("out_pc", out_pc, q[0].pc);
      check("out_data2", out_data2, q[0].data2);
      check("out_instr", out_instr, q[0].rd);
      check("out_rw", out_rw, q[0].rw);
      check("out_rwe", out_rwe, q[0].rwe);
    end else begin
      check("out_rw_masked", out_rw, 4'h0);
      check("out_rwe_masked", out_rwe, 1'b0);
    end
  endtask

  // One cycle: drive inputs at the falling edge, check just after, then advance the model.
  task automatic apply_stimulus(input logic v, input logic [31:0] alu, input logic rwe,
                                input logic ordy, input logic fl);
    exp_t e;
    logic acc;
    logic drn;
    @(negedge clk);
    e.alu   = alu;
    e.pc    = alu * 4 + 32'h1000;
    e.data2 = ~alu;
    e.rd    = alu[4:0] ^ 5'h11;
    e.rw    = alu[3:0] ^ 4'h5;
    e.rwe   = rwe;
    in_valid  = v;
    in_alu    = alu;
    in_pc     = e.pc;
    in_data2  = e.data2;
    in_imm    = alu << 3;
    in_instr  = e.rd;
    in_rw     = e.rw;
    in_rwe    = rwe;
    in_dms    = alu[0];
    in_wb     = alu[1:0];
    in_flush  = fl;
    out_ready = ordy;
    #1;
    check_output();
    drn = (q.size() > 0) && ordy;
    acc = v && (q.size() < 2);
    if ((q.size() > 0) && !ordy && (stall_m != 16'hFFFF)) stall_m++;
    if (fl) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    stall_m = 16'd0;
    reset = 1'b1;
    in_valid = 0; in_flush = 0; out_ready = 1; in_alu = 0; in_pc = 0; in_data2 = 0;
    in_imm = 0; in_instr = 0; in_rw = 0; in_rwe = 0; in_dms = 0; in_wb = 0;
    w_in_valid = 0; w_in_flush = 0; w_out_ready = 1; w_in_instr = 0;
    w_in_pc = 0; w_in_alu = 0; w_in_data2 = 0; w_in_imm = 0;
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] streaming");
    apply_stimulus(1'b1, 32'h1, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h2, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h3, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    $display("[TB] skid fill and drain");
    apply_stimulus(1'b1, 32'hA, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'hC, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'hC, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    $display("[TB] flush from FULL");
    apply_stimulus(1'b1, 32'h21, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h23, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    $display("[TB] flush with simultaneous drain");
    apply_stimulus(1'b1, 32'h31, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h32, 1'b1, 1'b1, 1'b1);
    apply_stimulus(1'b1, 32'h33, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    $display("[TB] asynchronous reset while FULL");
    apply_stimulus(1'b1, 32'h41, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h42, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_stall", out_stall, 16'd0);
    check("rst_alu", out_alu, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_data2", out_data2, 32'd0);
    check("rst_imm", out_imm, 32'd0);
    check("rst_instr", out_instr, 5'd0);
    check("rst_ctrl", {out_dms, out_rw, out_wb, out_rwe}, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    stall_m = 16'd0;
    apply_stimulus(1'b1, 32'h51, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    $display("[TB] wide variant and stall saturation");
    @(negedge clk);
    w_in_valid  = 1'b1;
    w_in_pc     = 64'hFFFF_FFFF_0000_1234;
    w_in_instr  = 6'h3F;
    w_in_alu    = 64'h0123_4567_89AB_CDEF;
    w_out_ready = 1'b0;
    @(negedge clk);
    w_in_valid = 1'b0;
    #1;
    check("w_out_valid", w_out_valid, 1'b1);
    check("w_out_pc", w_out_pc, 64'hFFFF_FFFF_0000_1234);
    check("w_out_instr", w_out_instr, 6'h3F);
    check("w_out_alu", w_out_alu, 64'h0123_4567_89AB_CDEF);
    check("w_stall_start", w_out_stall, 4'd0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      #1;
      check("w_stall", w_out_stall, (i > 15) ? 4'd15 : i[3:0]);
    end
    @(negedge clk);
    w_in_flush = 1'b1;
    @(negedge clk);
    w_in_flush = 1'b0;
    #1;
    check("w_flush_valid", w_out_valid, 1'b0);
    check("w_flush_ready", w_in_ready, 1'b1);
    check("w_flush_stall", w_out_stall, 4'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
